// File: rtl/multicore_mem_arbiter.sv
// Shared-RAM arbiter for NCORES cache clients.
// Data requests beat instruction requests. Among cores, a round-robin pointer
// picks the first requester at or after it. Only a completed grant advances
// the pointer. The grant, address, store data and rd/wr kind are latched in
// IDLE. The RAM side is then driven from those latched values until the RAM
// completes the access or the requester aborts.
module multicore_mem_arbiter #(
  parameter int NCORES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDW    = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES*ADDR_W-1:0] iaddr,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES*ADDR_W-1:0] daddr,
  input  logic [NCORES*DATA_W-1:0] dstore,
  output logic [NCORES-1:0]        iwait,
  output logic [NCORES-1:0]        dwait,
  output logic [DATA_W-1:0]        iload,
  output logic [DATA_W-1:0]        dload,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  state_t             state, state_n;
  logic [IDW-1:0]     grant_q, grant_n;
  logic [IDW-1:0]     ptr_q, ptr_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  store_q, store_n;
  logic               wr_q, wr_n;
  logic [NCORES-1:0]  dreq;
  logic [IDW-1:0]     dpick, ipick;
  logic               live;  // granted core still asserting its request
  logic               done;  // RAM completed (ACCESS or ERROR) this cycle

  // First requester at or after ptr, scanning cyclically.
  // Scanning from the far end down to ptr leaves the nearest requester in sel.
  function automatic logic [IDW-1:0] rr_pick(input logic [NCORES-1:0] req,
                                             input logic [IDW-1:0]    ptr);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] c;
    int             idx;
    sel = ptr;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCORES;
      c   = IDW'(idx);
      if (req[c]) sel = c;
    end
    return sel;
  endfunction

  assign dreq  = dREN | dWEN;
  assign dpick = rr_pick(dreq, ptr_q);
  assign ipick = rr_pick(iREN, ptr_q);

  // Next-state logic: grant selection in IDLE; completion or abort in the grant states.
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    ptr_n   = ptr_q;
    addr_n  = addr_q;
    store_n = store_q;
    wr_n    = wr_q;
    live    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (|dreq) begin
          state_n = DGRANT;
          grant_n = dpick;
          addr_n  = daddr[int'(dpick)*ADDR_W +: ADDR_W];
          store_n = dstore[int'(dpick)*DATA_W +: DATA_W];
          wr_n    = dWEN[dpick];  // dWEN wins over dREN on the same core
        end else if (|iREN) begin
          state_n = IGRANT;
          grant_n = ipick;
          addr_n  = iaddr[int'(ipick)*ADDR_W +: ADDR_W];
          store_n = '0;
          wr_n    = 1'b0;
        end
      end
      DGRANT, IGRANT: begin
        live = (state == DGRANT) ? dreq[grant_q] : iREN[grant_q];
        if (!live) begin
          // Abort: release the RAM. The pointer stays put, so this core is
          // still first in line for the next scan.
          state_n = IDLE;
        end else if (ramstate == RS_ACCESS || ramstate == RS_ERROR) begin
          done    = 1'b1;
          state_n = IDLE;
          ptr_n   = IDW'((int'(grant_q) + 1) % NCORES);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: RAM drive from latched values, and a one-cycle completion handshake.
  always_comb begin
    busy     = (state != IDLE);
    grant_id = grant_q;
    ramaddr  = busy ? addr_q  : '0;
    ramstore = busy ? store_q : '0;
    ramREN   = live & ~wr_q;
    ramWEN   = live & wr_q;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    err      = 1'b0;
    if (done) begin
      err = (ramstate == RS_ERROR);
      if (state == DGRANT) begin
        dwait[grant_q] = 1'b0;
        dload          = err ? '0 : ramload;
      end else begin
        iwait[grant_q] = 1'b0;
        iload          = err ? '0 : ramload;
      end
    end
  end

  // State and latched-request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      ptr_q   <= ptr_n;
      addr_q  <= addr_n;
      store_q <= store_n;
      wr_q    <= wr_n;
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Bench for multicore_mem_arbiter with NCORES=4.
// It applies a directed per-cycle vector table, then an async-reset sequence,
// then random traffic checked against a transaction-level reference model.
module tb_multicore_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    iREN, dREN, dWEN;
  logic [N*AW-1:0] iaddr, daddr;
  logic [N*DW-1:0] dstore;
  logic [N-1:0]    iwait, dwait;
  logic [DW-1:0]   iload, dload, ramstore, ramload;
  logic [AW-1:0]   ramaddr;
  logic            ramREN, ramWEN, busy, err;
  logic [1:0]      ramstate;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  multicore_mem_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate), .grant_id(grant_id),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  iren, dren, dwen;
    logic [1:0]  rs;
    logic [31:0] rload;
    logic        busy;
    logic [1:0]  gid;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [3:0]  iwait, dwait;
    logic [31:0] iload, dload;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t g(input logic [3:0] ir, dr, dw, input logic [1:0] rs,
                             input logic [31:0] rl, input logic [1:0] gid,
                             input logic ren, wen, input logic [31:0] addr, store,
                             input logic [3:0] iw, dwt, input logic [31:0] il, dl,
                             input logic e);
    vec_t v;
    v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs; v.rload = rl;
    v.busy = 1'b1; v.gid = gid; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.iwait = iw; v.dwait = dwt; v.iload = il; v.dload = dl; v.err = e;
    return v;
  endfunction

  function automatic vec_t idle(input logic [3:0] ir, dr, dw, input logic [1:0] rs);
    vec_t v;
    v = g(ir, dr, dw, rs, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0);
    v.busy = 1'b0;
    return v;
  endfunction

  // Reference pick: the first requesting core at or after p, scanning cyclically.
  function automatic int scan(input logic [N-1:0] r, input int p);
    for (int s = 0; s < N; s++) if (r[(p + s) % N]) return (p + s) % N;
    return -1;
  endfunction

  task automatic fixed_buses();
    for (int k = 0; k < N; k++) begin
      daddr[k*AW +: AW]  = 32'h40 * (k + 1);
      dstore[k*DW +: DW] = 32'h1134 + 32'h100 * k;
      iaddr[k*AW +: AW]  = 32'h1000 + 32'h10 * k;
    end
  endtask

  // Random-phase reference model state.
  logic [N-1:0] dp, dwr, ip;
  logic [31:0]  da[N], ds[N], ia[N];
  int           ptr_m, own_c;
  bit           own_v, own_d, own_w;
  logic [31:0]  own_a, own_s;

  initial begin
    localparam logic [31:0] L = 32'hA5A5_0000;
    vec_t       v;
    logic [3:0] ew;
    int         r;

    // reset state, with requests present during reset
    nRST = 1'b0; iREN = '0; dREN = 4'hF; dWEN = '0; ramstate = 2'd0; ramload = '0;
    fixed_buses();
    #12;
    chk("rst busy", busy, 0);        chk("rst iwait", iwait, 4'hF);
    chk("rst dwait", dwait, 4'hF);   chk("rst ramREN", ramREN, 0);
    chk("rst ramWEN", ramWEN, 0);    chk("rst ramaddr", ramaddr, 0);
    chk("rst ramstore", ramstore, 0); chk("rst iload", iload, 0);
    chk("rst dload", dload, 0);      chk("rst grant_id", grant_id, 0);
    chk("rst err", err, 0);
    dREN = '0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // round robin: all cores hold dREN, RAM answers immediately
    tbl.push_back(idle(0, 4'hF, 0, 2));
    tbl.push_back(g(0, 4'hF, 0, 2, L, 0, 1, 0, 32'h40, 0, 4'hF, 4'hE, 0, L, 0));
    tbl.push_back(idle(0, 4'hF, 0, 2));
    tbl.push_back(g(0, 4'hF, 0, 2, L, 1, 1, 0, 32'h80, 0, 4'hF, 4'hD, 0, L, 0));
    tbl.push_back(idle(0, 4'hF, 0, 2));
    tbl.push_back(g(0, 4'hF, 0, 2, L, 2, 1, 0, 32'hC0, 0, 4'hF, 4'hB, 0, L, 0));
    tbl.push_back(idle(0, 4'hF, 0, 2));
    tbl.push_back(g(0, 4'hF, 0, 2, L, 3, 1, 0, 32'h100, 0, 4'hF, 4'h7, 0, L, 0));
    tbl.push_back(idle(0, 4'hF, 0, 2));
    tbl.push_back(g(0, 4'hF, 0, 2, L, 0, 1, 0, 32'h40, 0, 4'hF, 4'hE, 0, L, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // single read with two BUSY cycles
    tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(g(0, 1, 0, 1, 0, 0, 1, 0, 32'h40, 0, 4'hF, 4'hF, 0, 0, 0));
    tbl.push_back(g(0, 1, 0, 1, 0, 0, 1, 0, 32'h40, 0, 4'hF, 4'hF, 0, 0, 0));
    tbl.push_back(g(0, 1, 0, 2, 32'hDEADBEEF, 0, 1, 0, 32'h40, 0, 4'hF, 4'hE, 0, 32'hDEADBEEF, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // data write beats instruction read
    tbl.push_back(idle(1, 0, 2, 0));
    tbl.push_back(g(1, 0, 2, 2, 32'h55, 1, 0, 1, 32'h80, 32'h1234, 4'hF, 4'hD, 0, 32'h55, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(g(1, 0, 0, 2, 32'hCAFE0001, 0, 1, 0, 32'h1000, 0, 4'hE, 4'hF, 32'hCAFE0001, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // error completion on core2, then check the pointer moved to core3
    tbl.push_back(idle(0, 4, 0, 0));
    tbl.push_back(g(0, 4, 0, 1, 0, 2, 1, 0, 32'hC0, 0, 4'hF, 4'hF, 0, 0, 0));
    tbl.push_back(g(0, 4, 0, 3, 32'hBAD, 2, 1, 0, 32'hC0, 0, 4'hF, 4'hB, 0, 0, 1));
    tbl.push_back(idle(0, 9, 0, 0));
    tbl.push_back(g(0, 9, 0, 2, 32'h33, 3, 1, 0, 32'h100, 0, 4'hF, 4'h7, 0, 32'h33, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // abort of core1 instruction read; the pointer must stay at core1's turn
    tbl.push_back(idle(2, 0, 0, 1));
    tbl.push_back(g(2, 0, 0, 1, 0, 1, 1, 0, 32'h1010, 0, 4'hF, 4'hF, 0, 0, 0));
    tbl.push_back(g(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0));
    tbl.push_back(idle(6, 0, 0, 1));
    tbl.push_back(g(6, 0, 0, 2, 32'h77, 1, 1, 0, 32'h1010, 0, 4'hD, 4'hF, 32'h77, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      iREN = v.iren; dREN = v.dren; dWEN = v.dwen; ramstate = v.rs; ramload = v.rload;
      @(negedge CLK);
      chk($sformatf("row%0d busy", i), busy, v.busy);
      chk($sformatf("row%0d iwait", i), iwait, v.iwait);
      chk($sformatf("row%0d dwait", i), dwait, v.dwait);
      chk($sformatf("row%0d iload", i), iload, v.iload);
      chk($sformatf("row%0d dload", i), dload, v.dload);
      chk($sformatf("row%0d err", i), err, v.err);
      chk($sformatf("row%0d ramREN", i), ramREN, v.ren);
      chk($sformatf("row%0d ramWEN", i), ramWEN, v.wen);
      if (v.busy) chk($sformatf("row%0d grant_id", i), grant_id, v.gid);
      if (v.ren || v.wen) chk($sformatf("row%0d ramaddr", i), ramaddr, v.addr);
      if (v.wen) chk($sformatf("row%0d ramstore", i), ramstore, v.store);
      @(posedge CLK); #1;
    end

    // async reset in the middle of a write grant (the pointer is at core2 here)
    dWEN = 4'b0010; ramstate = 2'd1;
    @(posedge CLK); #1;
    chk("ar pre ramWEN", ramWEN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("ar ramWEN", ramWEN, 0);   chk("ar ramREN", ramREN, 0);
    chk("ar dwait", dwait, 4'hF);  chk("ar iwait", iwait, 4'hF);
    chk("ar grant_id", grant_id, 0); chk("ar busy", busy, 0);
    dWEN = '0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    dREN = 4'b1001; ramstate = 2'd0;  // a pointer left at 2 would pick core3
    @(posedge CLK); #1;
    chk("ar ptr grant_id", grant_id, 0); chk("ar ptr busy", busy, 1);
    ramstate = 2'd2; ramload = 32'h600D;
    @(negedge CLK);
    chk("ar ptr dwait", dwait, 4'hE);  chk("ar ptr dload", dload, 32'h600D);
    @(posedge CLK); #1;
    dREN = '0; ramstate = 2'd0;

    // random traffic against a transaction-level model
    nRST = 1'b0; #3; nRST = 1'b1;
    @(posedge CLK); #1;
    dp = '0; dwr = '0; ip = '0; ptr_m = 0; own_v = 0; own_c = 0; own_d = 0; own_w = 0;
    own_a = '0; own_s = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!dp[k] && $urandom_range(0, 3) == 0) begin
          dp[k] = 1'b1; dwr[k] = 1'($urandom_range(0, 1)); da[k] = $urandom; ds[k] = $urandom;
        end
        if (!ip[k] && $urandom_range(0, 4) == 0) begin
          ip[k] = 1'b1; ia[k] = $urandom;
        end
        iREN[k] = ip[k];
        dWEN[k] = dp[k] & dwr[k];
        dREN[k] = dp[k] & (~dwr[k] | 1'($urandom_range(0, 1)));
        daddr[k*AW +: AW] = da[k]; dstore[k*DW +: DW] = ds[k]; iaddr[k*AW +: AW] = ia[k];
      end
      if (own_v) begin
        // the owner's buses change mid-grant; the latched values must hold
        if (own_d) begin
          daddr[own_c*AW +: AW] = $urandom; dstore[own_c*DW +: DW] = $urandom;
        end else iaddr[own_c*AW +: AW] = $urandom;
      end
      r = $urandom_range(0, 9);
      ramstate = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ramload = $urandom;
      @(negedge CLK);
      if (!own_v) begin
        chk("rnd idle busy", busy, 0);
        chk("rnd idle waits", {iwait, dwait}, 8'hFF);
        chk("rnd idle ram en", {ramREN, ramWEN}, 2'b00);
        chk("rnd idle err", err, 0);
        if (|dp) begin
          own_c = scan(dp, ptr_m); own_v = 1; own_d = 1;
          own_w = dwr[own_c]; own_a = da[own_c]; own_s = ds[own_c];
        end else if (|ip) begin
          own_c = scan(ip, ptr_m); own_v = 1; own_d = 0;
          own_w = 0; own_a = ia[own_c]; own_s = '0;
        end
      end else begin
        chk("rnd busy", busy, 1);
        chk("rnd grant_id", grant_id, own_c[1:0]);
        chk("rnd ramaddr", ramaddr, own_a);
        chk("rnd ramREN", ramREN, !own_w);
        chk("rnd ramWEN", ramWEN, own_w);
        if (own_w) chk("rnd ramstore", ramstore, own_s);
        ew = 4'hF;
        if (ramstate >= 2) ew[own_c] = 1'b0;
        chk("rnd dwait", dwait, own_d ? ew : 4'hF);
        chk("rnd iwait", iwait, own_d ? 4'hF : ew);
        chk("rnd dload", dload, (own_d && ramstate == 2) ? ramload : 32'h0);
        chk("rnd iload", iload, (!own_d && ramstate == 2) ? ramload : 32'h0);
        chk("rnd err", err, ramstate == 3);
        if (ramstate >= 2) begin
          if (own_d) dp[own_c] = 1'b0; else ip[own_c] = 1'b0;
          ptr_m = (own_c + 1) % N;
          own_v = 0;
        end
      end
      @(posedge CLK); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicore_mem_arbiter.md
Name: multicore_mem_arbiter

Overview:
Parametrised successor to the single-core memory controller. It arbitrates instruction and data requests from NCORES cache blocks onto one shared RAM port. Arbitration is registered: data requests beat instruction requests, and round-robin applies among cores. It sits between the per-core caches and the RAM-side interface in the multicore top level.

Parameters:
NCORES, 2, number of cache clients (2..8)
ADDR_W, 32, address width
DATA_W, 32, word width
IDW, $clog2(NCORES) (min 1), core-index width (derived)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
iREN  in  NCORES  per-core instruction read request
iaddr  in  NCORES*ADDR_W  per-core instruction address, core k at bits [k*ADDR_W +: ADDR_W]
dREN  in  NCORES  per-core data read request
dWEN  in  NCORES  per-core data write request (dREN&dWEN on the same core: write wins)
daddr  in  NCORES*ADDR_W  per-core data address
dstore  in  NCORES*DATA_W  per-core write data
iwait  out  NCORES  instruction wait, low only in the completion cycle
dwait  out  NCORES  data wait, low only in the completion cycle
iload  out  DATA_W  instruction read data, broadcast; valid when the matching iwait is low
dload  out  DATA_W  data read data, broadcast; valid when the matching dwait is low
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramload  in  DATA_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
grant_id  out  IDW  core currently owning the RAM
busy  out  1  high in any non-IDLE state
err  out  1  one-cycle pulse on ERROR completion

Behaviour:
- Reset values (async): iwait/dwait all 1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, grant_id=0, busy=0, err=0, rr pointer=0, state=IDLE.
- States: IDLE, DGRANT, IGRANT.
- IDLE: if any dREN|dWEN, pick the first requesting core at or after the rr pointer (cyclic scan); latch core, addr, store and rd/wr kind; go to DGRANT. Otherwise, if any iREN, pick the same way and go to IGRANT. Otherwise stay in IDLE.
- DGRANT/IGRANT: drive ramaddr/ramstore from the latched values. ramWEN = latched write; ramREN = read.
  - While ramstate is FREE or BUSY: hold.
  - On ACCESS: same cycle, the granted core's corresponding wait goes low for exactly 1 cycle and i/dload = ramload. Next state IDLE; rr pointer = (grant+1) mod NCORES.
  - On ERROR: complete identically to ACCESS, but load data = 0 and err pulses.
- Minimum latency: request seen in IDLE at cycle N; RAM is driven from N+1; with ACCESS at N+1, wait is low at N+1. Back-to-back grants have one IDLE cycle between them.
- Abort: if the granted core drops its request enable (iREN, or dREN|dWEN for data) while in a grant state, go to IDLE next cycle. No wait deassertion, no pointer advance, RAM enables drop that cycle.
- Starvation: no core waits more than NCORES data grants. Instruction requests may wait while any data request is pending; this is intended for cache-miss traffic.
- Addresses and data are latched at grant. Requester changes during a grant are ignored until completion.
- Non-granted cores keep waits high at all times.
- Reset mid-grant: enables drop immediately; the pending request is lost, and the core re-requests.

Test Plan:
- Single read: core0 dREN, daddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> dwait[0] low one cycle at N+3, dload=0xDEADBEEF, busy falls at N+4.
- Priority: core0 iREN and core1 dWEN (0x80, data 0x1234) in the same cycle -> write granted first (ramWEN=1, ramstore=0x1234); instruction granted after one IDLE cycle.
- Round robin, NCORES=4: all cores hold dREN continuously with immediate ACCESS -> grant_id sequence 0,1,2,3,0; each dwait low once per 4 grants.
- Error: ramstate=ERROR on a core2 read -> dwait[2] low, dload=0, err=1 for one cycle, rr pointer advances to 3.
- Abort: core1 iREN drops while ramstate=BUSY -> ramREN=0 next cycle, iwait[1] never low, next grant still starts the scan at core1.
- Async reset: nRST low during DGRANT with ramWEN=1 -> ramWEN=0 without a clock edge, all waits=1, grant_id=0.
